btn_event_arbiter: RTL and testbench



---
 rtl/btn_event_arbiter_if.sv | 41 ++++
 rtl/btn_event_arbiter.sv | 132 +++++++++++++
 tb/tb_btn_event_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_arbiter_if
// Brief    : Event channel bundle between the edge arbiter and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface btn_event_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   asynch_in;
    logic           evt_ack;
    logic           ovr_clr;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   overrun;

    // master: the arbiter offering events; slave: the consumer / input side
    modport master (
        input  asynch_in,
        input  evt_ack,
        input  ovr_clr,
        output evt_valid,
        output evt_id,
        output pending,
        output overrun
    );

    modport slave (
        output asynch_in,
        output evt_ack,
        output ovr_clr,
        input  evt_valid,
        input  evt_id,
        input  pending,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_arbiter
// Brief    : Per-channel sync/fall-detect/lockout, round-robin event serializer.
// Revision : 1.0 - initial release
// ============================================================================
module btn_event_arbiter #(
    parameter int N       = 4,
    parameter int LOCKOUT = 1000
) (
    input  wire                 clk,
    input  wire                 rst,
    btn_event_arbiter_if.master bus_io
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int LKW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [LKW-1:0] C_LK_LOAD = LKW'(LOCKOUT);
    localparam logic [IDW-1:0] C_LAST_RST = IDW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   overrun_q, overrun_d;

    logic [N-1:0]   w_fall;
    logic [N-1:0]   w_accept;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_ovr_set;
    logic           w_ack_fire;
    logic           w_found;
    logic [IDW-1:0] w_pick;

    assign w_ack_fire = (state_q == ST_OFFER) & bus_io.evt_ack;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        logic [2:0]     sync_q;
        logic [LKW-1:0] lk_q;
        logic [LKW-1:0] lk_d;

        // Chain resets high so an idle-high input never looks like a fall.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= 3'b111;
                lk_q   <= '0;
            end else begin
                sync_q <= {sync_q[1:0], bus_io.asynch_in[gi]};
                lk_q   <= lk_d;
            end
        end

        assign w_fall[gi]   = ~sync_q[1] & sync_q[2];
        assign w_accept[gi] = w_fall[gi] & (lk_q == '0);
        assign w_clr[gi]    = w_ack_fire & (id_q == IDW'(gi));

        always_comb begin
            lk_d = lk_q;
            if (w_accept[gi]) begin
                lk_d = C_LK_LOAD;
            end else if (lk_q != '0) begin
                lk_d = lk_q - LKW'(1);
            end
        end
    end

    // A new edge arriving while its own pending bit is being acked is not lost.
    always_comb begin
        w_ovr_set = w_accept & pending_q & ~w_clr;
        pending_d = (pending_q & ~w_clr) | w_accept;
        overrun_d = w_ovr_set | (bus_io.ovr_clr ? '0 : overrun_q);
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int j = 1; j <= N; j++) begin
            if (!w_found && pending_q[IDW'((int'(last_q) + j) % N)]) begin
                w_found = 1'b1;
                w_pick  = IDW'((int'(last_q) + j) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            last_q    <= C_LAST_RST;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    id_d    = w_pick;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (bus_io.evt_ack) begin
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_io.evt_valid = (state_q == ST_OFFER);
    assign bus_io.evt_id    = id_q;
    assign bus_io.pending   = pending_q;
    assign bus_io.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_arbiter
// Brief    : Vector table, directed sequences and random traffic vs a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_event_arbiter;
    localparam int N       = 4;
    localparam int LOCKOUT = 8;
    localparam int IDW     = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    btn_event_arbiter_if #(.N(N)) bus ();

    btn_event_arbiter #(.N(N), .LOCKOUT(LOCKOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct {
        logic [N-1:0]   in;
        logic           ack;
        logic           clr;
        logic           exp_valid;
        logic [IDW-1:0] exp_id;
        logic [N-1:0]   exp_pend;
        logic [N-1:0]   exp_ovr;
    } vec_t;

    vec_t tbl [8];

    int n_checks = 0;
    int n_fail   = 0;
    int n_got;
    logic [31:0] seq;

    // Reference model: inputs as a sample history, lockout as the edge index of
    // the last accepted fall, arbiter as "which channel is on offer".
    logic [N-1:0] smp [$];
    int           tlast [N];
    int           cyc;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovr;
    logic         m_offer;
    int           m_id;
    int           m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        smp.delete();
        for (int i = 0; i < 3; i++) smp.push_back('1);
        for (int i = 0; i < N; i++) tlast[i] = -1000;
        cyc     = 0;
        m_pend  = '0;
        m_ovr   = '0;
        m_offer = 1'b0;
        m_id    = 0;
        m_last  = N - 1;
    endtask

    task automatic model_step(input logic [N-1:0] in, input logic ack, input logic clr);
        logic [N-1:0] fallv;
        logic [N-1:0] old_pend;
        logic [N-1:0] new_pend;
        logic [N-1:0] setv;
        logic         took;
        cyc++;
        smp.push_back(in);
        // fall seen at this edge: high three samples back, low two samples back
        fallv = smp[smp.size()-4] & ~smp[smp.size()-3];
        if (smp.size() > 4) void'(smp.pop_front());
        old_pend = m_pend;
        new_pend = m_pend;
        setv     = '0;
        for (int i = 0; i < N; i++) begin
            took = m_offer && ack && (m_id == i);
            if (fallv[i] && (cyc - tlast[i] > LOCKOUT)) begin
                tlast[i] = cyc;
                if (old_pend[i] && !took) setv[i] = 1'b1;
                new_pend[i] = 1'b1;
            end else if (took) begin
                new_pend[i] = 1'b0;
            end
        end
        m_ovr = clr ? setv : (m_ovr | setv);
        if (m_offer) begin
            if (ack) begin
                m_offer = 1'b0;
                m_last  = m_id;
            end
        end else if (old_pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (old_pend[c]) begin
                    m_id    = c;
                    m_offer = 1'b1;
                    break;
                end
            end
        end
        m_pend = new_pend;
    endtask

    function automatic logic [31:0] dut_bundle();
        return 32'({bus.evt_valid, bus.evt_id, bus.pending, bus.overrun});
    endfunction

    task automatic step(input logic [N-1:0] in, input logic ack, input logic clr);
        logic [IDW-1:0] eid;
        bus.asynch_in = in;
        bus.evt_ack   = ack;
        bus.ovr_clr   = clr;
        @(posedge clk);
        model_step(in, ack, clr);
        #1;
        eid = IDW'(m_id);
        chk("model", dut_bundle(), 32'({m_offer, eid, m_pend, m_ovr}));
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.asynch_in = '1;
        bus.evt_ack   = 1'b0;
        bus.ovr_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Acks each offer on the cycle after it appears; records the id order.
    task automatic collect(input logic [N-1:0] in, input int budget);
        logic ack;
        n_got = 0;
        seq   = '0;
        for (int c = 0; c < budget; c++) begin
            ack = bus.evt_valid;
            if (ack) begin
                n_got++;
                seq = (seq << 4) | 32'(bus.evt_id);
            end
            step(in, ack, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [N-1:0] rin;

        tbl[0] = '{4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[1] = '{4'hB, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[2] = '{4'hB, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[3] = '{4'hB, 1'b1, 1'b0, 1'b0, 2'd0, 4'h4, 4'h0};
        tbl[4] = '{4'hB, 1'b1, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0};
        tbl[5] = '{4'hB, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0};
        tbl[6] = '{4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0};
        tbl[7] = '{4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0};

        // Quiet after reset
        do_reset();
        chk("reset_state", dut_bundle(), 32'h0);
        for (int c = 0; c < 50; c++) step('1, 1'b0, 1'b0);
        chk("quiet_50", dut_bundle(), 32'h0);

        // Single fall on channel 2 with ack tied high
        do_reset();
        for (int r = 0; r < 8; r++) begin
            step(tbl[r].in, tbl[r].ack, tbl[r].clr);
            chk($sformatf("vec%0d", r), dut_bundle(),
                32'({tbl[r].exp_valid, tbl[r].exp_id, tbl[r].exp_pend, tbl[r].exp_ovr}));
        end

        // Simultaneous falls: round-robin order from reset, then from last=3
        do_reset();
        collect(4'b0100, 20);
        chk("rr_count_3", 32'(n_got), 32'd3);
        chk("rr_order_013", seq, 32'h013);
        for (int c = 0; c < 12; c++) step('1, 1'b0, 1'b0);
        collect(4'b0110, 20);
        chk("rr_count_2", 32'(n_got), 32'd2);
        chk("rr_order_03", seq, 32'h03);

        // Lockout: gap 5 suppressed, gap 12 delivered
        do_reset();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step((c < 2 || c == 5 || c == 6) ? 4'hD : 4'hF, 1'b1, 1'b0);
            if (bus.evt_valid && bus.evt_id == 2'd1) cnt++;
        end
        chk("lockout_gap5", 32'(cnt), 32'd1);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step((c < 2 || c == 12 || c == 13) ? 4'hD : 4'hF, 1'b1, 1'b0);
            if (bus.evt_valid && bus.evt_id == 2'd1) cnt++;
        end
        chk("lockout_gap12", 32'(cnt), 32'd2);

        // Overrun while the consumer stalls, then clear
        do_reset();
        for (int c = 0; c < 20; c++)
            step((c < 3 || (c >= 13 && c < 16)) ? 4'hB : 4'hF, 1'b0, 1'b0);
        chk("ovr_set", 32'(bus.overrun), 32'h4);
        chk("ovr_pending_held", 32'(bus.pending), 32'h4);
        collect('1, 12);
        chk("ovr_single_event", 32'(n_got), 32'd1);
        chk("ovr_sticky", 32'({bus.pending, bus.overrun}), 32'h04);
        step('1, 1'b0, 1'b1);
        chk("ovr_clr", 32'(bus.overrun), 32'h0);

        // Asynchronous reset during an offer
        do_reset();
        for (int c = 0; c < 4; c++) step(4'h7, 1'b0, 1'b0);
        chk("offer_before_rst", 32'({bus.evt_valid, bus.evt_id}), 32'h7);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_drop", 32'({bus.evt_valid, bus.pending}), 32'h0);
        do_reset();
        for (int c = 0; c < 3; c++) step('1, 1'b0, 1'b0);
        collect(4'hC, 20);
        chk("post_rst_order", seq, 32'h01);

        // Random traffic against the model
        do_reset();
        rin = '1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) rin[i] = ~rin[i];
            step(rin, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
